// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the 4-digit 7-segment scanner.
// Segment vectors are [0:7] = a..g, dp and active-low, so the literal's MSB is segment a.
package seg_pkg;

  localparam int NUM_DIG = 4;

  typedef logic [0:7] seg_t;

  localparam seg_t SEG_0    = 8'b0000_0011;
  localparam seg_t SEG_1    = 8'b1001_1111;
  localparam seg_t SEG_2    = 8'b0010_0101;
  localparam seg_t SEG_3    = 8'b0000_1101;
  localparam seg_t SEG_4    = 8'b1001_1001;
  localparam seg_t SEG_5    = 8'b0100_1001;
  localparam seg_t SEG_6    = 8'b0100_0001;
  localparam seg_t SEG_7    = 8'b0001_1111;
  localparam seg_t SEG_8    = 8'b0000_0001;
  localparam seg_t SEG_9    = 8'b0000_1001;
  localparam seg_t SEG_DASH = 8'b1111_1101;
  localparam seg_t SEG_OFF  = 8'hFF;

  typedef enum logic [1:0] {IDLE, BLANK, DRIVE} state_t;

  // One displayable frame: data[15:12]/dp[3] is digit1 (leftmost).
  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
  } frame_t;

  // Pattern for a nibble with the decimal point off; non-BCD codes show a dash.
  function automatic seg_t bcd_pattern(input logic [3:0] n);
    case (n)
      4'd0:    bcd_pattern = SEG_0;
      4'd1:    bcd_pattern = SEG_1;
      4'd2:    bcd_pattern = SEG_2;
      4'd3:    bcd_pattern = SEG_3;
      4'd4:    bcd_pattern = SEG_4;
      4'd5:    bcd_pattern = SEG_5;
      4'd6:    bcd_pattern = SEG_6;
      4'd7:    bcd_pattern = SEG_7;
      4'd8:    bcd_pattern = SEG_8;
      4'd9:    bcd_pattern = SEG_9;
      default: bcd_pattern = SEG_DASH;
    endcase
  endfunction

endpackage

// File: rtl/bcd_to_seg.sv
// bcd_to_seg: combinational BCD nibble + decimal point to active-low segments.
module bcd_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  output logic [0:7] seg
);

  // Look up the digit pattern, then drive dp (active low) on segment 7.
  always_comb begin
    seg    = bcd_pattern(bcd);
    seg[7] = ~dp;
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: time-sliced 4-digit common-anode display scanner with
// dead band per slot and frame-boundary (tear-free) updates.
// Optional macro SEG_LZB_EN enables leading-zero blanking on digit1..digit3.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int TICK_DIV  = 25_000,
  parameter int BLANK_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [15:0] load_data,
  input  logic [3:0]  load_dp,
  output logic [0:7]  seg,
  output logic        digit1,
  output logic        digit2,
  output logic        digit3,
  output logic        digit4,
  output logic        frame_done
);

  localparam int CW = $clog2(TICK_DIV);

  state_t              state, state_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic [1:0]          idx, idx_n;
  frame_t              active, pending;
  logic                pend_full, rdy_ok;
  logic                boundary, accept, xfer;
  logic [3:0]          nib;
  logic                nib_dp;
  logic [NUM_DIG-1:0]  lzb;
  seg_t                dec_seg, seg_n, seg_q;
  logic [NUM_DIG-1:0]  dig_n, dig_q;
  logic                fd_n, fd_q;

  // Last drive cycle of digit4 with scanning still enabled.
  assign boundary   = (state == DRIVE) && (cnt == CW'(TICK_DIV - 1)) &&
                      (idx == 2'd3) && enable;
  assign load_ready = rdy_ok & ~pend_full;
  assign accept     = load_valid & load_ready;
  assign xfer       = boundary | (state == IDLE);

  // Double buffer: pending is promoted to active only at a frame boundary or while idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      active    <= '0;
      pending   <= '0;
      pend_full <= 1'b0;
      rdy_ok    <= 1'b0;
    end else begin
      rdy_ok <= 1'b1;
      if (xfer && pend_full) begin
        active    <= pending;
        pend_full <= 1'b0;
      end
      if (accept) begin
        pending   <= '{data: load_data, dp: load_dp};
        pend_full <= 1'b1;
      end
    end
  end

  // State, slot counter, digit index and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      seg_q <= SEG_OFF;
      dig_q <= '1;
      fd_q  <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
      seg_q <= seg_n;
      dig_q <= dig_n;
      fd_q  <= fd_n;
    end
  end

  // Next state: cnt runs 0..TICK_DIV-1 across a slot; blank phase is the first BLANK_CYC counts.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    if (!enable) begin
      state_n = IDLE;
      cnt_n   = '0;
      idx_n   = '0;
    end else begin
      case (state)
        IDLE: begin
          state_n = BLANK;
          cnt_n   = '0;
          idx_n   = '0;
        end
        BLANK: begin
          cnt_n = cnt + 1'b1;
          if (cnt == CW'(BLANK_CYC - 1)) state_n = DRIVE;
        end
        DRIVE: begin
          if (cnt == CW'(TICK_DIV - 1)) begin
            state_n = BLANK;
            cnt_n   = '0;
            idx_n   = idx + 2'd1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Select the digit about to be driven; ~idx maps digit1 to the top nibble.
  assign nib    = active.data[{~idx_n, 2'b00} +: 4];
  assign nib_dp = active.dp[~idx_n];

  bcd_to_seg u_dec (
    .bcd (nib),
    .dp  (nib_dp),
    .seg (dec_seg)
  );

`ifdef SEG_LZB_EN
  logic lead;
  // A digit is blanked while it and every digit to its left are zero with dp clear.
  always_comb begin
    lead = 1'b1;
    lzb  = '0;
    for (int i = 0; i < NUM_DIG - 1; i++) begin
      lead   = lead & (active.data[4*(3-i) +: 4] == 4'd0) & ~active.dp[3-i];
      lzb[i] = lead;
    end
  end
`else
  assign lzb = '0;
`endif

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    seg_n = SEG_OFF;
    dig_n = '1;
    fd_n  = boundary;
    if (state_n == DRIVE) begin
      dig_n[idx_n] = 1'b0;
      seg_n        = lzb[idx_n] ? SEG_OFF : dec_seg;
    end
  end

  assign seg        = seg_q;
  assign digit1     = dig_q[0];
  assign digit2     = dig_q[1];
  assign digit3     = dig_q[2];
  assign digit4     = dig_q[3];
  assign frame_done = fd_q;

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Multiplexing scheduler for the 4-digit common-anode 7-segment display. It time-slices the shared segment bus between digit1..digit4, inserts a dead band between slots to prevent ghosting, and decodes BCD with per-digit decimal point. New values are accepted through a valid/ready handshake and applied only at frame boundaries, so a frame never tears. It sits between the counter/datapath logic and the display pins, replacing free-running divided-clock scanning.

## Interface
- TICK_DIV, 25_000: clk cycles per digit slot (blank + drive); ≥ BLANK_CYC+2
- BLANK_CYC, 64: dead cycles at start of each slot, all digits off; ≥ 1
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-low
- enable  in  1  scan enable; low = display dark
- load_valid  in  1  new frame data offered
- load_ready  out  1  pending buffer empty, can accept
- load_data  in  16  four BCD nibbles; [15:12]=digit1 (leftmost/MS) … [3:0]=digit4
- load_dp  in  4  decimal points; [3]=digit1 … [0]=digit4
- seg  out  [0:7]  active-low segments; 0=a … 6=g, 7=dp
- digit1..digit4  out  1 each  active-low digit enables
- frame_done  out  1  one-cycle pulse at end of digit4 drive

## Operation
- Two registers: active (displayed) and pending (+ pending_full flag). Accept when load_valid && load_ready → pending, pending_full=1; load_ready = !pending_full.
- Transfer pending→active (clear pending_full): at frame boundary (last drive cycle of digit4), or in any IDLE cycle.
- Accept in the same cycle as a boundary with pending empty: data lands in pending, applied at next boundary.
- FSM: IDLE → (enable) BLANK → DRIVE → BLANK (next digit) …
  - IDLE: all digits 1, seg 8'hFF, idx=0, slot counter 0.
  - BLANK: BLANK_CYC cycles, all digits off, seg 8'hFF.
  - DRIVE: TICK_DIV−BLANK_CYC cycles, digit[idx]=0, seg=decode(active[idx]). On exit idx wraps 3→0; exit from idx 3 pulses frame_done.
  - enable low in any state → IDLE next cycle, outputs dark, idx reset; re-enable restarts at digit1 BLANK.
- Decode: 0–9 standard patterns; nibble 10–15 → "-" (g only). dp bit drives seg[7].
- Outputs registered; at most one digit enable low at any cycle.

## Timing
- Reset (rst=0 at clk edge): state IDLE, seg=8'hFF, digits all 1, frame_done=0, load_ready=0 while rst low, 1 the cycle after release; active=0, pending empty.
- enable rising at edge N: BLANK cycles N+1..N+BLANK_CYC, digit1 low from N+BLANK_CYC+1 for TICK_DIV−BLANK_CYC cycles.
- Slot period TICK_DIV; frame period 4·TICK_DIV cycles exactly.
- frame_done high the cycle digit4 deasserts; new active values visible from next digit1 drive.
- Reset mid-frame overrides everything, pending discarded.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking — digit1..digit3 whose value is 0 and all more-significant digits are 0 with dp clear are driven seg=8'hFF (digit enable still cycles); digit4 always shown; a set dp stops blanking at that digit.
- Undefined: every digit decoded as-is, zeros shown.

## Structure
- Package seg_pkg: segment pattern constants for 0–9, SEG_DASH, SEG_OFF (8'hFF), FSM state enum (IDLE/BLANK/DRIVE).
- Sub-module bcd_to_seg: combinational nibble+dp → active-low seg[0:7]; instanced once on the muxed digit.

## Test plan
Bench params TICK_DIV=8, BLANK_CYC=2.
- Reset then enable=1, no load → digits scan 1,2,3,4 with 2 dark cycles + 6 drive each, seg=0 pattern (8'b0000_0011 inverted per package), frame_done every 32 cycles.
- Load 16'h1234, dp=4'b0100 while IDLE → applied immediately; digit2 drive shows "2" with seg[7]=0.
- Load 16'h5678 mid-frame → load_ready drops next cycle, old digits until frame_done, then digit1 shows "5", load_ready returns 1.
- Second load_valid while pending full → held off (ready=0), accepted after boundary; value 16'hABCD shows "-" on all digits.
- enable dropped during digit3 drive → next cycle all digits 1, seg=8'hFF; re-enable restarts at digit1.
- SEG_LZB_EN, load 16'h0070 → digit1,digit2 blank, digit3 "7", digit4 "0"; without macro digit1 shows "0".
